uart_lite_responder: RTL

AXI4-Lite responder implementing the UART-Lite register map (RX FIFO at 0x0, TX FIFO at 0x4, STAT at 0x8, CTRL at 0xC) in front of two byte FIFOs with a valid/ready byte-stream side. It is the slave end of the core's `in`/`out` polling sequence: it sits on the core's AXI-Lite port in simulation and FPGA loopback builds, and connects on its byte side to a serializer or a testbench byte source/sink.

---
 rtl/uart_lite_pkg.sv | 45 ++++
 rtl/uart_lite_responder_fifo.sv | 52 +++++
 rtl/uart_lite_responder.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_lite_pkg.sv
// Shared register map, status/control bit positions, AXI response codes
// and FSM state encodings for the UART-Lite responder.
package uart_lite_pkg;

   localparam logic [3:0] RX_FIFO_OFS = 4'h0;
   localparam logic [3:0] TX_FIFO_OFS = 4'h4;
   localparam logic [3:0] STAT_OFS    = 4'h8;
   localparam logic [3:0] CTRL_OFS    = 4'hC;

   localparam int STAT_RX_VALID = 0;
   localparam int STAT_RX_FULL  = 1;
   localparam int STAT_TX_EMPTY = 2;
   localparam int STAT_TX_FULL  = 3;

   localparam int CTRL_TX_CLR = 0;
   localparam int CTRL_RX_CLR = 1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef logic [0:0] w_state_t;
   localparam w_state_t W_IDLE = 1'b0;
   localparam w_state_t W_RESP = 1'b1;

   typedef logic [1:0] r_state_t;
   localparam r_state_t R_IDLE = 2'd0;
   localparam r_state_t R_ADDR = 2'd1;
   localparam r_state_t R_DATA = 2'd2;

   function automatic logic [31:0] stat_word(
      input logic rx_valid,
      input logic rx_full,
      input logic tx_empty,
      input logic tx_full
   );
      logic [31:0] s;
      s                = '0;
      s[STAT_RX_VALID] = rx_valid;
      s[STAT_RX_FULL]  = rx_full;
      s[STAT_TX_EMPTY] = tx_empty;
      s[STAT_TX_FULL]  = tx_full;
      return s;
   endfunction

endpackage

// File: rtl/uart_lite_responder_fifo.sv
// sync_fifo: single-clock FIFO with an extra pointer wrap bit and a
// synchronous clear that overrides same-cycle push and pop.
module sync_fifo
   import uart_lite_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   input  logic             clear,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] dout
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_push;
   logic             w_pop;

   assign empty = (r_wr_ptr == r_rd_ptr);
   assign full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                  (r_wr_ptr[AW] != r_rd_ptr[AW]);

   // Flags come from the current pointers, so a same-cycle pop never
   // frees room for a push and a same-cycle push never feeds a pop.
   assign w_push = push & ~full;
   assign w_pop  = pop & ~empty;
   assign dout   = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst || clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !clear) r_mem[r_wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/uart_lite_responder.sv
// AXI4-Lite UART-Lite register front end over TX/RX byte FIFOs.
// Define UART_LITE_CTRL_EN to make CTRL writes clear the FIFOs.
module uart_lite_responder
   import uart_lite_pkg::*;
#(
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] s_axi_awaddr,
   input  logic        s_axi_awvalid,
   output logic        s_axi_awready,
   input  logic [31:0] s_axi_wdata,
   input  logic [3:0]  s_axi_wstrb,
   input  logic        s_axi_wvalid,
   output logic        s_axi_wready,
   output logic [1:0]  s_axi_bresp,
   output logic        s_axi_bvalid,
   input  logic        s_axi_bready,
   input  logic [31:0] s_axi_araddr,
   input  logic        s_axi_arvalid,
   output logic        s_axi_arready,
   output logic [31:0] s_axi_rdata,
   output logic [1:0]  s_axi_rresp,
   output logic        s_axi_rvalid,
   input  logic        s_axi_rready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready
);

   w_state_t    r_wstate;
   r_state_t    r_rstate;
   logic        r_awready;
   logic        r_wready;
   logic        r_aw_got;
   logic        r_w_got;
   logic [3:0]  r_awaddr;
   logic [7:0]  r_wdata;
   logic        r_wstrb0;
   logic        r_bvalid;
   logic [1:0]  r_bresp;
   logic        r_arready;
   logic        r_rvalid;
   logic [31:0] r_rdata;
   logic [1:0]  r_rresp;
   logic        r_live;

   logic        w_aw_hs;
   logic        w_w_hs;
   logic        w_wr_fire;
   logic [3:0]  w_waddr;
   logic [7:0]  w_wbyte;
   logic        w_wstrb0;
   logic [1:0]  w_bresp;
   logic        w_tx_push;
   logic        w_ctrl_wr;
   logic        w_tx_clr;
   logic        w_rx_clr;
   logic        w_rd_fire;
   logic [3:0]  w_raddr;
   logic [31:0] w_rdata;
   logic [1:0]  w_rresp;
   logic        w_rx_pop;
   logic        w_tx_full;
   logic        w_tx_empty;
   logic        w_rx_full;
   logic        w_rx_empty;
   logic [7:0]  w_rx_dout;
   logic        w_unused;

   assign w_unused = ^{s_axi_awaddr[31:4], s_axi_wdata[31:8],
                       s_axi_wstrb[3:1], s_axi_araddr[31:4]};

   assign s_axi_awready = r_awready;
   assign s_axi_wready  = r_wready;
   assign s_axi_bvalid  = r_bvalid;
   assign s_axi_bresp   = r_bresp;
   assign s_axi_arready = r_arready;
   assign s_axi_rvalid  = r_rvalid;
   assign s_axi_rdata   = r_rdata;
   assign s_axi_rresp   = r_rresp;

   assign tx_valid = ~w_tx_empty;
   assign rx_ready = r_live & ~w_rx_full;

   // Write channel: AW and W may complete in either order or together.
   assign w_aw_hs   = s_axi_awvalid & r_awready;
   assign w_w_hs    = s_axi_wvalid & r_wready;
   assign w_wr_fire = (r_wstate == W_IDLE) &
                      (r_aw_got | w_aw_hs) & (r_w_got | w_w_hs);
   assign w_waddr   = r_aw_got ? r_awaddr : s_axi_awaddr[3:0];
   assign w_wbyte   = r_w_got ? r_wdata : s_axi_wdata[7:0];
   assign w_wstrb0  = r_w_got ? r_wstrb0 : s_axi_wstrb[0];

   always_comb begin
      w_bresp   = RESP_OKAY;
      w_tx_push = 1'b0;
      w_ctrl_wr = 1'b0;
      if (w_waddr[1:0] != 2'b00) begin
         w_bresp = RESP_SLVERR;
      end else if (w_waddr == TX_FIFO_OFS && w_wstrb0) begin
         if (w_tx_full) w_bresp = RESP_SLVERR;
         else           w_tx_push = w_wr_fire;
      end else if (w_waddr == CTRL_OFS && w_wstrb0) begin
         w_ctrl_wr = w_wr_fire;
      end
   end

`ifdef UART_LITE_CTRL_EN
   assign w_tx_clr = w_ctrl_wr & w_wbyte[CTRL_TX_CLR];
   assign w_rx_clr = w_ctrl_wr & w_wbyte[CTRL_RX_CLR];
`else
   logic w_unused_ctrl;
   assign w_unused_ctrl = w_ctrl_wr;
   assign w_tx_clr      = 1'b0;
   assign w_rx_clr      = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wstate  <= W_IDLE;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_aw_got  <= 1'b0;
         r_w_got   <= 1'b0;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_wstrb0  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
      end else begin
         unique case (r_wstate)
            W_IDLE: begin
               r_awready <= s_axi_awvalid & ~r_aw_got & ~r_awready;
               r_wready  <= s_axi_wvalid & ~r_w_got & ~r_wready;
               if (w_aw_hs) begin
                  r_aw_got <= 1'b1;
                  r_awaddr <= s_axi_awaddr[3:0];
               end
               if (w_w_hs) begin
                  r_w_got  <= 1'b1;
                  r_wdata  <= s_axi_wdata[7:0];
                  r_wstrb0 <= s_axi_wstrb[0];
               end
               if (w_wr_fire) begin
                  r_aw_got  <= 1'b0;
                  r_w_got   <= 1'b0;
                  r_awready <= 1'b0;
                  r_wready  <= 1'b0;
                  r_bvalid  <= 1'b1;
                  r_bresp   <= w_bresp;
                  r_wstate  <= W_RESP;
               end
            end
            W_RESP: begin
               if (s_axi_bready) begin
                  r_bvalid <= 1'b0;
                  r_bresp  <= RESP_OKAY;
                  r_wstate <= W_IDLE;
               end
            end
         endcase
      end
   end

   // Read channel: decode and RX pop happen on the edge that ends arready.
   assign w_rd_fire = (r_rstate == R_ADDR) & s_axi_arvalid;
   assign w_raddr   = s_axi_araddr[3:0];

   always_comb begin
      w_rdata  = '0;
      w_rresp  = RESP_OKAY;
      w_rx_pop = 1'b0;
      if (w_raddr[1:0] != 2'b00) begin
         w_rresp = RESP_SLVERR;
      end else if (w_raddr == RX_FIFO_OFS) begin
         w_rdata  = {24'd0, w_rx_dout};
         w_rx_pop = w_rd_fire & ~w_rx_empty;
      end else if (w_raddr == STAT_OFS) begin
         w_rdata = stat_word(~w_rx_empty, w_rx_full, w_tx_empty, w_tx_full);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_rstate  <= R_IDLE;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_rresp   <= RESP_OKAY;
      end else begin
         unique case (r_rstate)
            R_IDLE: begin
               if (s_axi_arvalid) begin
                  r_arready <= 1'b1;
                  r_rstate  <= R_ADDR;
               end
            end
            R_ADDR: begin
               r_arready <= 1'b0;
               if (w_rd_fire) begin
                  r_rdata  <= w_rdata;
                  r_rresp  <= w_rresp;
                  r_rvalid <= 1'b1;
                  r_rstate <= R_DATA;
               end else begin
                  r_rstate <= R_IDLE;
               end
            end
            R_DATA: begin
               if (s_axi_rready) begin
                  r_rvalid <= 1'b0;
                  r_rdata  <= '0;
                  r_rresp  <= RESP_OKAY;
                  r_rstate <= R_IDLE;
               end
            end
            default: r_rstate <= R_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) r_live <= 1'b0;
      else      r_live <= 1'b1;
   end

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_tx_push),
      .din   (w_wbyte),
      .pop   (tx_valid & tx_ready),
      .clear (w_tx_clr),
      .full  (w_tx_full),
      .empty (w_tx_empty),
      .dout  (tx_data)
   );

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rx_valid & rx_ready),
      .din   (rx_data),
      .pop   (w_rx_pop),
      .clear (w_rx_clr),
      .full  (w_rx_full),
      .empty (w_rx_empty),
      .dout  (w_rx_dout)
   );

endmodule
